// File: rtl/flux_frame_sequencer_if.sv
// Frame-streaming bus between the FFT magnitude buffer, the flux datapath and the sequencer.
// The sequencer drives the master modport; the buffer/datapath side uses slave.
interface flux_frame_sequencer_if #(
  parameter int BIN_LENGTH = 10
);
  logic                  fft_ready;
  logic                  flux_valid;
  logic                  fft_rd_en;
  logic [BIN_LENGTH-1:0] fft_rd_addr;
  logic                  mag_valid;
  logic [BIN_LENGTH-1:0] bin_index;
  logic                  frame_done;
  logic                  fft_release;

  modport master (
    input  fft_ready, flux_valid,
    output fft_rd_en, fft_rd_addr, mag_valid, bin_index, frame_done, fft_release
  );

  modport slave (
    output fft_ready, flux_valid,
    input  fft_rd_en, fft_rd_addr, mag_valid, bin_index, frame_done, fft_release
  );
endinterface

// File: rtl/flux_frame_sequencer.sv
// Streams one FFT magnitude frame into the flux datapath, drains it, then waits for the flux result.
// Define FLUX_SEQ_OVERRUN_CNT_EN to add the saturating overrun_count output.
module flux_frame_sequencer #(
  parameter int N            = 1024,
  parameter int BIN_LENGTH   = 10,
  parameter int FLUSH_CYCLES = 4,
  parameter int FLUX_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  flux_frame_sequencer_if.master        bus,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic                          timeout_flag
`ifdef FLUX_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]                    overrun_count
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, WAIT_FLUX} state_t;

  localparam logic [BIN_LENGTH-1:0] LAST_ADDR  = BIN_LENGTH'(N - 1);
  localparam logic [3:0]            LAST_FLUSH = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0]            LAST_WAIT  = 8'(FLUX_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [BIN_LENGTH-1:0] addr_q, addr_d;
  logic [3:0]            flush_q, flush_d;
  logic [7:0]            wait_q, wait_d;
  logic                  pending_q, pending_d;
  logic                  flux_q;
  logic                  flux_rise;
  logic                  rd_en;
  logic                  done_pulse;
  logic                  count_frame;
  logic                  timed_out;
  logic                  mag_valid_q;
  logic [BIN_LENGTH-1:0] bin_index_q;

  assign flux_rise = bus.flux_valid & ~flux_q;

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    flush_d     = flush_q;
    wait_d      = wait_q;
    rd_en       = 1'b0;
    done_pulse  = 1'b0;
    count_frame = 1'b0;
    timed_out   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.fft_ready || pending_q) begin
          state_d = STREAM;
          addr_d  = '0;
        end
      end
      STREAM: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          flush_d = '0;
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + BIN_LENGTH'(1);
        end
      end
      FLUSH: begin
        if (flush_q == LAST_FLUSH) begin
          done_pulse = 1'b1;
          flush_d    = '0;
          wait_d     = '0;
          state_d    = WAIT_FLUX;
        end else begin
          flush_d = flush_q + 4'(1);
        end
      end
      WAIT_FLUX: begin
        // A rise on the final allowed cycle still counts as a published result.
        if (flux_rise) begin
          count_frame = 1'b1;
          state_d     = IDLE;
        end else if (wait_q == LAST_WAIT) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 8'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Leaving IDLE consumes the pending request; a coincident fft_ready takes its place.
  always_comb begin
    pending_d = pending_q;
    if (state_q == IDLE) begin
      pending_d = pending_q & bus.fft_ready;
    end else if (bus.fft_ready && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      flush_q      <= '0;
      wait_q       <= '0;
      pending_q    <= 1'b0;
      flux_q       <= 1'b0;
      mag_valid_q  <= 1'b0;
      bin_index_q  <= '0;
      frame_count  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      flush_q     <= flush_d;
      wait_q      <= wait_d;
      pending_q   <= pending_d;
      flux_q      <= bus.flux_valid;
      mag_valid_q <= rd_en;
      bin_index_q <= addr_q;
      if (count_frame) frame_count <= frame_count + 16'(1);
      if (timed_out) timeout_flag <= 1'b1;
    end
  end

`ifdef FLUX_SEQ_OVERRUN_CNT_EN
  logic overrun_drop;
  assign overrun_drop = bus.fft_ready && (state_q != IDLE) && pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (overrun_drop && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'(1);
    end
  end
`endif

  assign bus.fft_rd_en   = rd_en;
  assign bus.fft_rd_addr = addr_q;
  assign bus.mag_valid   = mag_valid_q;
  assign bus.bin_index   = bin_index_q;
  assign bus.frame_done  = done_pulse;
  assign bus.fft_release = done_pulse;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_flux_frame_sequencer.sv
// Directed bench for flux_frame_sequencer with N=16, FLUSH_CYCLES=4, FLUX_TIMEOUT=8.
// Cycle 0 of each scenario is the cycle in which the first fft_ready is driven.
module tb_flux_frame_sequencer;
  localparam int N  = 16;
  localparam int BL = 4;
  localparam int FC = 4;
  localparam int FT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] frame_count;
  logic        timeout_flag;
`ifdef FLUX_SEQ_OVERRUN_CNT_EN
  logic [7:0]  overrun_count;
`endif

  flux_frame_sequencer_if #(.BIN_LENGTH(BL)) bus ();

  flux_frame_sequencer #(
    .N(N), .BIN_LENGTH(BL), .FLUSH_CYCLES(FC), .FLUX_TIMEOUT(FT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .frame_count  (frame_count),
    .timeout_flag (timeout_flag)
`ifdef FLUX_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_test();
    step();
    cyc = 0;
  endtask

  // Expected read/valid/done pattern for a frame whose first STREAM cycle is s.
  task automatic check_stream(input int s);
    logic exp_en, exp_mv, exp_done;
    exp_en   = (cyc >= s) && (cyc < s + N);
    exp_mv   = (cyc >= s + 1) && (cyc < s + N + 1);
    exp_done = (cyc == s + N + FC - 1);
    check("fft_rd_en",   32'(bus.fft_rd_en),   32'(exp_en));
    check("fft_rd_addr", 32'(bus.fft_rd_addr), exp_en ? 32'(cyc - s) : 32'd0);
    check("mag_valid",   32'(bus.mag_valid),   32'(exp_mv));
    check("bin_index",   32'(bus.bin_index),   exp_mv ? 32'(cyc - s - 1) : 32'd0);
    check("frame_done",  32'(bus.frame_done),  32'(exp_done));
    check("fft_release", 32'(bus.fft_release), 32'(exp_done));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " fft_rd_en"},    32'(bus.fft_rd_en),    32'd0);
    check({tag, " fft_rd_addr"},  32'(bus.fft_rd_addr),  32'd0);
    check({tag, " mag_valid"},    32'(bus.mag_valid),    32'd0);
    check({tag, " bin_index"},    32'(bus.bin_index),    32'd0);
    check({tag, " frame_done"},   32'(bus.frame_done),   32'd0);
    check({tag, " fft_release"},  32'(bus.fft_release),  32'd0);
    check({tag, " busy"},         32'(busy),             32'd0);
    check({tag, " frame_count"},  32'(frame_count),      32'd0);
    check({tag, " timeout_flag"}, 32'(timeout_flag),     32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.fft_ready  = 1'b0;
    bus.flux_valid = 1'b0;
    step();
    step();
    check_all_zero("reset");
`ifdef FLUX_SEQ_OVERRUN_CNT_EN
    check("reset overrun_count", 32'(overrun_count), 32'd0);
`endif
    reset = 1'b0;
    step();

    // Single frame: stream 1..16, done at 20, flux rise at 23, IDLE at 24.
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (24) begin
      step();
      bus.fft_ready  = 1'b0;
      bus.flux_valid = (cyc == 23);
      check_stream(1);
      check("t1 busy",        32'(busy),        32'(cyc <= 23));
      check("t1 frame_count", 32'(frame_count), (cyc == 24) ? 32'd1 : 32'd0);
    end
    bus.flux_valid = 1'b0;
    step();
    step();

    // Back-to-back: second request pends during STREAM, restarts at 24 after exit at 23.
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (47) begin
      step();
      bus.fft_ready  = (cyc == 5);
      bus.flux_valid = (cyc == 22) || (cyc == 46);
      check_stream((cyc < 24) ? 1 : 24);
      check("t2 busy",        32'(busy),        32'(!(cyc == 23 || cyc == 47)));
      check("t2 frame_count", 32'(frame_count), (cyc < 23) ? 32'd1 : ((cyc < 47) ? 32'd2 : 32'd3));
    end
    bus.flux_valid = 1'b0;
    step();
    step();

    // Overrun: requests at 0, 3, 6 -> one pending frame, one dropped.
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (45) begin
      step();
      bus.fft_ready  = (cyc == 3) || (cyc == 6);
      bus.flux_valid = (cyc == 21) || (cyc == 43);
      check_stream((cyc < 23) ? 1 : 23);
      check("t3 busy",        32'(busy),        32'(!(cyc == 22 || cyc >= 44)));
      check("t3 frame_count", 32'(frame_count), (cyc < 22) ? 32'd3 : ((cyc < 44) ? 32'd4 : 32'd5));
    end
`ifdef FLUX_SEQ_OVERRUN_CNT_EN
    check("t3 overrun_count", 32'(overrun_count), 32'd1);
`endif
    bus.flux_valid = 1'b0;
    step();
    step();

    // Timeout at 29 with a request on the exit cycle; then flux already high on entry
    // must wait for a fresh edge (rise at 54 -> IDLE at 55).
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (56) begin
      step();
      bus.fft_ready  = (cyc == 28);
      bus.flux_valid = (cyc >= 48 && cyc <= 52) || (cyc >= 54);
      check_stream((cyc < 30) ? 1 : 30);
      check("t4 busy",         32'(busy),         32'(!(cyc == 29 || cyc >= 55)));
      check("t4 timeout_flag", 32'(timeout_flag), 32'(cyc >= 29));
      check("t4 frame_count",  32'(frame_count),  (cyc < 55) ? 32'd5 : 32'd6);
    end
    bus.flux_valid = 1'b0;
    step();
    step();

    // Reset at address 7 aborts the frame; flux edges in IDLE are ignored.
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (8) begin
      step();
      bus.fft_ready = 1'b0;
      check_stream(1);
    end
    reset = 1'b1;
    step();
    check_all_zero("t5 after reset");
    reset = 1'b0;
    repeat (25) begin
      step();
      bus.flux_valid = (cyc == 12);
      check("t5 idle busy",        32'(busy),           32'd0);
      check("t5 idle frame_done",  32'(bus.frame_done), 32'd0);
      check("t5 idle frame_count", 32'(frame_count),    32'd0);
    end
    bus.flux_valid = 1'b0;
    step();

    // Restart from address 0; a flux edge during STREAM must not count a frame.
    begin_test();
    bus.fft_ready = 1'b1;
    repeat (24) begin
      step();
      bus.fft_ready  = 1'b0;
      bus.flux_valid = (cyc == 3) || (cyc == 23);
      check_stream(1);
      check("t6 busy",        32'(busy),        32'(cyc <= 23));
      check("t6 frame_count", 32'(frame_count), (cyc == 24) ? 32'd1 : 32'd0);
    end
    bus.flux_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
